event_encoder4: RTL and testbench

- Sequential 4-to-2 encoder; the inverse of the team's 2-to-4 decoder (D0..D3 <-> A,B).
- Captures rising edges on four request lines and queues them as pending.
- Emits one 2-bit code {A,B} per accepted event over a VALID/READY handshake, highest priority first.
- Sits between raw event/button lines and any consumer that expects a binary index, e.g. a downstream Decoder4.

---
 rtl/event_encoder4_if.sv | 24 ++
 rtl/event_encoder4.sv | 129 ++++++++++++
 tb/tb_event_encoder4.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/event_encoder4_if.sv
// Handshake bundle between event_encoder4 and its consumer: raw request lines in,
// registered 2-bit code with VALID/READY, pending bitmap and sticky overflow out.
interface event_encoder4_if;
    logic       d0;
    logic       d1;
    logic       d2;
    logic       d3;
    logic       ready;
    logic       a;
    logic       b;
    logic       valid;
    logic [3:0] pend;
    logic       ovf;

    modport master (
        input  d0, d1, d2, d3, ready,
        output a, b, valid, pend, ovf
    );

    modport slave (
        output d0, d1, d2, d3, ready,
        input  a, b, valid, pend, ovf
    );
endinterface

// File: rtl/event_encoder4.sv
// Sequential 4-to-2 encoder: rising edges on four request lines are queued as pending
// bits and issued as 2-bit codes over VALID/READY in priority order.

// One request line: synchronizer, edge detector and its pending bit.
module event_encoder4_lane #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic clr,
    output logic pend,
    output logic ovf_hit
);
    logic s;
    logic s_prev;
    logic rise;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = d;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= d;
                    for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign rise = s & ~s_prev;

    // A new rise beats a same-edge load, so the freshly raised bit survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_prev <= 1'b0;
            pend   <= 1'b0;
        end else begin
            s_prev <= s;
            if (rise)     pend <= 1'b1;
            else if (clr) pend <= 1'b0;
        end
    end

    // Duplicate rise onto a bit that is still queued: that event is lost.
    assign ovf_hit = rise & pend & ~clr;
endmodule

module event_encoder4 #(
    parameter int SYNC_STAGES = 2,
    parameter bit HIGH_FIRST  = 1'b1
) (
    input logic              clk,
    input logic              rst,
    event_encoder4_if.master bus
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0] d;
    logic [NUM_LANES-1:0] pend;
    logic [NUM_LANES-1:0] clr;
    logic [NUM_LANES-1:0] ovf_hit;
    logic [1:0]           sel;
    logic                 free;
    logic                 load;
    logic                 a_q;
    logic                 b_q;
    logic                 valid_q;
    logic                 ovf_q;

    assign d = {bus.d3, bus.d2, bus.d1, bus.d0};

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            event_encoder4_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
                .clk    (clk),
                .rst    (rst),
                .d      (d[i]),
                .clr    (clr[i]),
                .pend   (pend[i]),
                .ovf_hit(ovf_hit[i])
            );
        end
    endgenerate

    // Last match in scan order wins, so the scan runs from lowest to highest priority.
    always_comb begin
        sel = 2'd0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < NUM_LANES; i++) if (pend[i]) sel = 2'(i);
        end else begin
            for (int i = NUM_LANES-1; i >= 0; i--) if (pend[i]) sel = 2'(i);
        end
    end

    assign free = ~valid_q | bus.ready;
    assign load = free & (|pend);
    assign clr  = load ? (4'b0001 << sel) : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (free) begin
                if (|pend) begin
                    {a_q, b_q} <= sel;
                    valid_q    <= 1'b1;
                end else begin
                    valid_q    <= 1'b0;
                end
            end
            if (|ovf_hit) ovf_q <= 1'b1;
        end
    end

    assign bus.a     = a_q;
    assign bus.b     = b_q;
    assign bus.valid = valid_q;
    assign bus.pend  = pend;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_event_encoder4.sv
// Bench for event_encoder4: two instances (HIGH_FIRST=1 and 0) share stimulus and are
// compared each cycle against a queue-of-pending-events model, plus directed literal checks.
module tb_event_encoder4;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] d = 4'b0000;
    logic       ready = 1'b0;
    int         checks = 0;
    int         failures = 0;
    int         cnt;

    always #5 clk = ~clk;

    event_encoder4_if if0 ();
    event_encoder4_if if1 ();

    assign if0.d0 = d[0];
    assign if0.d1 = d[1];
    assign if0.d2 = d[2];
    assign if0.d3 = d[3];
    assign if0.ready = ready;
    assign if1.d0 = d[0];
    assign if1.d1 = d[1];
    assign if1.d2 = d[2];
    assign if1.d3 = d[3];
    assign if1.ready = ready;

    event_encoder4 #(.SYNC_STAGES(SS), .HIGH_FIRST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.master));
    event_encoder4 #(.SYNC_STAGES(SS), .HIGH_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.master));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [3:0] m_syn [0:2];
    bit [3:0] m_prev;
    bit [3:0] m_pend  [2];
    bit [1:0] m_code  [2];
    bit       m_valid [2];
    bit       m_ovf   [2];

    function automatic int pick(bit [3:0] p, bit hf);
        if (hf) begin
            for (int i = 3; i >= 0; i--) if (p[i]) return i;
        end else begin
            for (int i = 0; i < 4; i++) if (p[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin : m_step
        bit [3:0] s, rise, taken;
        int idx;
        if (rst) begin
            for (int k = 0; k < 3; k++) m_syn[k] = 4'b0;
            m_prev = 4'b0;
            for (int n = 0; n < 2; n++) begin
                m_pend[n] = 4'b0; m_code[n] = 2'b0; m_valid[n] = 1'b0; m_ovf[n] = 1'b0;
            end
        end else begin
            s      = (SS == 0) ? d : m_syn[SS-1];
            rise   = s & ~m_prev;
            m_prev = s;
            m_syn[2] = m_syn[1];
            m_syn[1] = m_syn[0];
            m_syn[0] = d;
            for (int n = 0; n < 2; n++) begin
                taken = 4'b0;
                if (!m_valid[n] || ready) begin
                    idx = pick(m_pend[n], n == 0);
                    if (idx >= 0) begin
                        m_code[n]  = idx[1:0];
                        m_valid[n] = 1'b1;
                        taken      = 4'b0001 << idx;
                    end else begin
                        m_valid[n] = 1'b0;
                    end
                end
                if (|(rise & m_pend[n] & ~taken)) m_ovf[n] = 1'b1;
                m_pend[n] = (m_pend[n] & ~taken) | rise;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("m0_valid", if0.valid, m_valid[0]);
            chk("m0_code", {if0.a, if0.b}, m_code[0]);
            chk("m0_pend", if0.pend, m_pend[0]);
            chk("m0_ovf", if0.ovf, m_ovf[0]);
            chk("m1_valid", if1.valid, m_valid[1]);
            chk("m1_code", {if1.a, if1.b}, m_code[1]);
            chk("m1_pend", if1.pend, m_pend[1]);
            chk("m1_ovf", if1.ovf, m_ovf[1]);
        end
    end

    task automatic pulse(input int idx);
        d[idx] = 1'b1;
        @(negedge clk);
        d[idx] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", if0.valid, 0);
        chk("rst_pend", if0.pend, 0);
        chk("rst_ovf", if0.ovf, 0);
        chk("rst_code", {if0.a, if0.b}, 0);
        rst = 1'b0;

        // single D2 event, 4-edge latency, one-cycle VALID
        ready = 1'b1;
        @(negedge clk);
        d[2] = 1'b1;
        repeat (3) @(negedge clk);
        chk("single_pend", if0.pend, 4'b0100);
        chk("single_early_valid", if0.valid, 0);
        @(negedge clk);
        chk("single_valid", if0.valid, 1);
        chk("single_code", {if0.a, if0.b}, 2'b10);
        chk("single_pend_clr", if0.pend, 0);
        @(negedge clk);
        chk("single_drain", if0.valid, 0);
        d = 4'b0000;
        repeat (4) @(negedge clk);

        // simultaneous D0 + D3
        d = 4'b1001;
        repeat (3) @(negedge clk);
        chk("simul_pend", if0.pend, 4'b1001);
        @(negedge clk);
        chk("simul_hf_code1", {if0.a, if0.b}, 2'b11);
        chk("simul_hf_pend1", if0.pend, 4'b0001);
        chk("simul_lf_code1", {if1.a, if1.b}, 2'b00);
        chk("simul_lf_pend1", if1.pend, 4'b1000);
        @(negedge clk);
        chk("simul_hf_code2", {if0.a, if0.b}, 2'b00);
        chk("simul_lf_code2", {if1.a, if1.b}, 2'b11);
        chk("simul_hf_valid2", if0.valid, 1);
        chk("simul_pend2", if0.pend, 0);
        d = 4'b0000;
        repeat (4) @(negedge clk);

        // backpressure
        ready = 1'b0;
        d[1] = 1'b1;
        @(negedge clk);
        d[2] = 1'b1;
        repeat (4) @(negedge clk);
        chk("bp_code", {if0.a, if0.b}, 2'b01);
        chk("bp_valid", if0.valid, 1);
        chk("bp_pend", if0.pend, 4'b0100);
        ready = 1'b1;
        @(negedge clk);
        chk("bp_next_code", {if0.a, if0.b}, 2'b10);
        chk("bp_no_bubble", if0.valid, 1);
        ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("bp_hold_code", {if0.a, if0.b}, 2'b10);
        chk("bp_hold_valid", if0.valid, 1);
        d = 4'b0000;
        ready = 1'b1;
        repeat (4) @(negedge clk);

        // overflow
        ready = 1'b0;
        pulse(1);
        pulse(1);
        pulse(1);
        chk("ovf_set", if0.ovf, 1);
        chk("ovf_model", m_ovf[0], 1);
        chk("ovf_pend", if0.pend, 4'b0010);
        chk("ovf_code", {if0.a, if0.b}, 2'b01);
        ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("ovf_drained", if0.valid, 0);
        chk("ovf_sticky", if0.ovf, 1);

        // asynchronous reset mid-cycle with work queued
        ready = 1'b0;
        pulse(2);
        d = 4'b1010;
        repeat (4) @(negedge clk);
        chk("pre_rst_pend", if0.pend, 4'b1010);
        chk("pre_rst_valid", if0.valid, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", if0.valid, 0);
        chk("async_pend", if0.pend, 0);
        chk("async_ovf", if0.ovf, 0);
        chk("async_code", {if0.a, if0.b}, 0);
        chk("async_model_pend", m_pend[0], 0);
        @(negedge clk);
        d = 4'b0000;
        @(negedge clk);
        rst = 1'b0;

        // held level gives one event, re-arm after a low period
        ready = 1'b1;
        repeat (4) @(negedge clk);
        d[0] = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (if0.valid) begin
                cnt++;
                chk("held_code", {if0.a, if0.b}, 2'b00);
            end
        end
        chk("held_pulses", cnt, 1);
        d[0] = 1'b0;
        repeat (3) @(negedge clk);
        d[0] = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (if0.valid) cnt++;
        end
        chk("rearm_pulses", cnt, 1);
        d = 4'b0000;
        repeat (4) @(negedge clk);

        // randomized traffic, occasional mid-cycle reset
        repeat (3000) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 3) == 0) d[i] = ~d[i];
            ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
